// File: rtl/dqn_pkg.sv
// Shared constants, FSM state type and the Q-format saturation helper for the
// layer-2 output MAC of the DQN datapath.
package dqn_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int N_HID     = 9;
    localparam int N_OUT     = 5;
    localparam int ACC_W     = 36;
    localparam int ST_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    // Drop the fractional bits (floor) and clamp into the signed 16-bit range.
    function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        logic [DATA_W-1:0]       res;
        sh = acc >>> FRAC_BITS;
        if (sh > SAT_MAX) begin
            res = 16'h7FFF;
        end else if (sh < SAT_MIN) begin
            res = 16'h8000;
        end else begin
            res = sh[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/q_layer2_mac_lane.sv
// One output lane: multiplier, wide accumulator and saturated Q-value register.
module mac_lane
    import dqn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              ld,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] h,
    output logic [DATA_W-1:0] q
);

    logic signed [31:0]       prod_s;
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic [DATA_W-1:0]        q_d, q_q;

    // Full-precision product, accumulate, and capture of the saturated result.
    always_comb begin
        prod_s = $signed(w) * $signed(h);
        acc_d  = acc_q;
        q_d    = q_q;
        if (clr) begin
            acc_d = {ACC_W{1'b0}};
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W-32){prod_s[31]}}, prod_s};
        end else begin
            acc_d = acc_q;
        end
        if (ld) begin
            q_d = sat16(acc_q);
        end else begin
            q_d = q_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {ACC_W{1'b0}};
            q_q   <= 16'h0000;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/q_layer2_mac.sv
// Output-layer forward pass: walks the hidden index, drives five MAC lanes and
// pulses done when q1..q5 are valid. Optional argmax: define Q_LAYER2_ARGMAX_EN.
module q_layer2_mac
    import dqn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] h_st,
    input  logic [15:0] w2_1,
    input  logic [15:0] w2_2,
    input  logic [15:0] w2_3,
    input  logic [15:0] w2_4,
    input  logic [15:0] w2_5,
    output logic [3:0]  st,
    output logic        busy,
    output logic        done,
    output logic [15:0] q1,
    output logic [15:0] q2,
    output logic [15:0] q3,
    output logic [15:0] q4,
    output logic [15:0] q5,
    output logic [2:0]  action,
    output logic [15:0] q_max
);

    state_e            state_d, state_q;
    logic [ST_W-1:0]   st_d, st_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              clr_s, en_s, ld_s;
    logic [DATA_W-1:0] w_s [N_OUT];
    logic [DATA_W-1:0] q_s [N_OUT];

    assign w_s[0] = w2_1;
    assign w_s[1] = w2_2;
    assign w_s[2] = w2_3;
    assign w_s[3] = w2_4;
    assign w_s[4] = w2_5;

    // Next-state, index counter and lane controls.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        case (state_q)
            IDLE: begin
                st_d = 4'd0;
                if (start) begin
                    state_d = ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (st_q == ST_W'(N_HID - 1)) begin
                    state_d = SAT;
                end else begin
                    st_d = st_q + 4'd1;
                end
            end
            SAT: begin
                state_d = DONE;
                st_d    = 4'd0;
            end
            DONE: begin
                state_d = IDLE;
                st_d    = 4'd0;
            end
            default: begin
                state_d = IDLE;
                st_d    = 4'd0;
            end
        endcase
        busy_d = (state_d == ACC) || (state_d == SAT);
        // done trails DONE by one register so q, action and q_max are all settled.
        done_d = (state_q == DONE);
        clr_s  = (state_q == IDLE) && start;
        en_s   = (state_q == ACC);
        ld_s   = (state_q == SAT);
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        mac_lane u_lane (
            .clk (clk),
            .rst (rst),
            .clr (clr_s),
            .en  (en_s),
            .ld  (ld_s),
            .w   (w_s[k]),
            .h   (h_st),
            .q   (q_s[k])
        );
    end

`ifdef Q_LAYER2_ARGMAX_EN
    logic [2:0]        action_d, action_q;
    logic [DATA_W-1:0] q_max_d, q_max_q;
    logic [2:0]        best_idx_s;
    logic [DATA_W-1:0] best_val_s;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_idx_s = 3'd0;
        best_val_s = q_s[0];
        for (int k = 1; k < N_OUT; k++) begin
            if ($signed(q_s[k]) > $signed(best_val_s)) begin
                best_idx_s = 3'(k);
                best_val_s = q_s[k];
            end else begin
                best_idx_s = best_idx_s;
                best_val_s = best_val_s;
            end
        end
        if (state_q == DONE) begin
            action_d = best_idx_s;
            q_max_d  = best_val_s;
        end else begin
            action_d = action_q;
            q_max_d  = q_max_q;
        end
    end

    // Argmax result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            action_q <= 3'd0;
            q_max_q  <= 16'h0000;
        end else begin
            action_q <= action_d;
            q_max_q  <= q_max_d;
        end
    end

    assign action = action_q;
    assign q_max  = q_max_q;
`else
    assign action = 3'd0;
    assign q_max  = 16'h0000;
`endif

    assign st   = st_q;
    assign busy = busy_q;
    assign done = done_q;
    assign q1   = q_s[0];
    assign q2   = q_s[1];
    assign q3   = q_s[2];
    assign q4   = q_s[3];
    assign q5   = q_s[4];

endmodule

// File: tb/tb_q_layer2_mac.sv
// Directed bench for q_layer2_mac: uniform-pattern vector table plus
// hand-written sequences for indexing, truncation, reset and argmax.
module tb_q_layer2_mac;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] h_st, w2_1, w2_2, w2_3, w2_4, w2_5;
    logic [3:0]  st;
    logic        busy, done;
    logic [15:0] q1, q2, q3, q4, q5, q_max;
    logic [2:0]  action;

    logic [15:0] w_tab [5][9];
    logic [15:0] h_tab [9];
    logic [15:0] snap_q [5];
    logic [2:0]  snap_action;
    logic [15:0] snap_qmax;

    int nchecks = 0;
    int nerrors = 0;

    typedef struct {
        logic [15:0] w;
        logic [15:0] h;
        logic [15:0] q_exp;
    } vec_t;

    vec_t vecs [7];

    q_layer2_mac dut (
        .clk(clk), .rst(rst), .start(start), .h_st(h_st),
        .w2_1(w2_1), .w2_2(w2_2), .w2_3(w2_3), .w2_4(w2_4), .w2_5(w2_5),
        .st(st), .busy(busy), .done(done),
        .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5),
        .action(action), .q_max(q_max)
    );

    always #5 clk = ~clk;

    // Upstream weight store and activation source, indexed combinationally by st.
    always_comb begin
        h_st = 16'h0000; w2_1 = 16'h0000; w2_2 = 16'h0000;
        w2_3 = 16'h0000; w2_4 = 16'h0000; w2_5 = 16'h0000;
        if (st < 4'd9) begin
            h_st = h_tab[st];
            w2_1 = w_tab[0][st]; w2_2 = w_tab[1][st]; w2_3 = w_tab[2][st];
            w2_4 = w_tab[3][st]; w2_5 = w_tab[4][st];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                           input logic [15:0] e3, input logic [15:0] e4, input logic [15:0] e5);
        check({tag, " q1"}, {16'h0, snap_q[0]}, {16'h0, e1});
        check({tag, " q2"}, {16'h0, snap_q[1]}, {16'h0, e2});
        check({tag, " q3"}, {16'h0, snap_q[2]}, {16'h0, e3});
        check({tag, " q4"}, {16'h0, snap_q[3]}, {16'h0, e4});
        check({tag, " q5"}, {16'h0, snap_q[4]}, {16'h0, e5});
    endtask

    task automatic clear_tabs();
        for (int i = 0; i < 9; i++) begin
            h_tab[i] = 16'h0000;
            for (int k = 0; k < 5; k++) w_tab[k][i] = 16'h0000;
        end
    endtask

    task automatic set_uniform(input logic [15:0] w, input logic [15:0] h);
        for (int i = 0; i < 9; i++) begin
            h_tab[i] = h;
            for (int k = 0; k < 5; k++) w_tab[k][i] = w;
        end
    endtask

    // One forward pass: checks latency, busy length, st walk and done width.
    task automatic run_pass(input string tag);
        int lat;
        int bcnt;
        bit st_ok;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        lat = -1; bcnt = 0; st_ok = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (busy) bcnt++;
            if (n <= 8 && st !== 4'(n)) st_ok = 1'b0;
            if (done) begin
                lat = n;
                snap_q[0] = q1; snap_q[1] = q2; snap_q[2] = q3;
                snap_q[3] = q4; snap_q[4] = q5;
                snap_action = action; snap_qmax = q_max;
                break;
            end
        end
        check({tag, " latency"}, lat, 32'd11);
        check({tag, " busy cycles"}, bcnt, 32'd10);
        check({tag, " st walk"}, {31'd0, st_ok}, 32'd1);
        check({tag, " st at done"}, {28'd0, st}, 32'd0);
        @(posedge clk); #1;
        check({tag, " done width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int found;
        int dcnt;
        int gap;

        vecs[0] = '{16'h0100, 16'h0100, 16'h0900};
        vecs[1] = '{16'h7F00, 16'h7F00, 16'h7FFF};
        vecs[2] = '{16'h8100, 16'h7F00, 16'h8000};
        vecs[3] = '{16'h0080, 16'h0100, 16'h0480};
        vecs[4] = '{16'hFF00, 16'h0100, 16'hF700};
        vecs[5] = '{16'hFF80, 16'h0080, 16'hFDC0};
        vecs[6] = '{16'h0000, 16'h1234, 16'h0000};

        rst = 1'b1; start = 1'b0;
        clear_tabs();
        repeat (2) @(posedge clk);
        #1;
        check("reset st", {28'd0, st}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset q1", {16'h0, q1}, 32'd0);
        check("reset q5", {16'h0, q5}, 32'd0);
        check("reset action", {29'd0, action}, 32'd0);
        check("reset q_max", {16'h0, q_max}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            set_uniform(vecs[v].w, vecs[v].h);
            run_pass($sformatf("vec%0d", v));
            check_q($sformatf("vec%0d", v), vecs[v].q_exp, vecs[v].q_exp,
                    vecs[v].q_exp, vecs[v].q_exp, vecs[v].q_exp);
        end

        // Floor on the fractional shift: -1 LSB product must become -1, not 0.
        clear_tabs();
        h_tab[3] = 16'hFFFF; w_tab[0][3] = 16'h0001;
        run_pass("trunc");
        check_q("trunc", 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        clear_tabs();
        for (int i = 0; i < 9; i++) begin
            h_tab[i] = 16'((i + 1) << 8);
            for (int k = 0; k < 5; k++) w_tab[k][i] = 16'((k + 1) << 8);
        end
        run_pass("column");
        check_q("column", 16'h2D00, 16'h5A00, 16'h7FFF, 16'h7FFF, 16'h7FFF);

        // Reset in the middle of a pass discards it with no done pulse.
        set_uniform(16'h0100, 16'h0100);
        run_pass("pre_rst");
        check_q("pre_rst", 16'h0900, 16'h0900, 16'h0900, 16'h0900, 16'h0900);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            if (st == 4'd4) begin found = 1; break; end
            @(posedge clk); #1;
        end
        check("mid reach st4", found, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid rst st", {28'd0, st}, 32'd0);
        check("mid rst busy", {31'd0, busy}, 32'd0);
        check("mid rst done", {31'd0, done}, 32'd0);
        check("mid rst q1", {16'h0, q1}, 32'd0);
        check("mid rst q3", {16'h0, q3}, 32'd0);
        check("mid rst q5", {16'h0, q5}, 32'd0);
        dcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
            if (busy) dcnt++;
        end
        check("mid rst no done", dcnt, 32'd0);
        run_pass("post_rst");
        check_q("post_rst", 16'h0900, 16'h0900, 16'h0900, 16'h0900, 16'h0900);

        // Held start: back-to-back passes, done pulses N_HID+3 cycles apart.
        @(negedge clk); start = 1'b1;
        found = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) begin found = 1; break; end
        end
        check("held first done", found, 32'd1);
        gap = -1;
        for (int n = 1; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) begin gap = n; break; end
        end
        start = 1'b0;
        check("held spacing", gap, 32'd12);
        repeat (3) @(posedge clk);
        #1;
        check("held stops", {31'd0, busy}, 32'd0);

        // Argmax: q = {1.0, 5.0, 5.0, 2.0, -3.0}; tie between lanes 2 and 3.
        clear_tabs();
        h_tab[0] = 16'h0100;
        w_tab[0][0] = 16'h0100; w_tab[1][0] = 16'h0500; w_tab[2][0] = 16'h0500;
        w_tab[3][0] = 16'h0200; w_tab[4][0] = 16'hFD00;
        run_pass("argmax");
        check_q("argmax", 16'h0100, 16'h0500, 16'h0500, 16'h0200, 16'hFD00);
`ifdef Q_LAYER2_ARGMAX_EN
        check("argmax action", {29'd0, snap_action}, 32'd1);
        check("argmax q_max", {16'h0, snap_qmax}, 32'h0500);
`else
        check("argmax action off", {29'd0, snap_action}, 32'd0);
        check("argmax q_max off", {16'h0, snap_qmax}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
